shift_issue: RTL and testbench
==============================

# shift_issue

Pipelined issue/capture stage wrapped around the combinational multi-stage right shifter. It accepts shift requests (data plus binary shift amount) over a valid/ready handshake, registers them, and decodes the amount into the shifter's priority select vector. It captures the shifted result together with sticky and zero flags and a request tag, and presents it downstream over a second valid/ready handshake. Full throughput: one request per cycle, 2-cycle latency.

## Interface
- N, 16, data width; also the number of shifter select lines.
- W, $clog2(N), width of amount field minus one (amount port is W+1 bits, so 0..N is representable).
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_data  input  N  operand to shift right (logical).
- in_amt  input  W+1  unsigned shift amount; values >= N shift everything out.
- sh_x  output  N  operand to shifter (x port).
- sh_sel  output  N  select vector to shifter (s port).
- sh_o  input  N  shifter result (o port), combinational from sh_x/sh_sel.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  N  in_data >> in_amt (logical, zero fill).
- out_sticky  output  1  OR of all bits shifted out.
- out_zero  output  1  out_data == 0.
- out_tag  output  8  sequence number of the request (accept order, mod 256).

## Operation
- Stage 1 (S1) registers: s1_valid, s1_x, s1_sel, s1_sticky, s1_tag. Stage 2 (S2) registers: out_valid, out_data, out_sticky, out_zero, out_tag.
- Select decode at accept: amt < N -> sel = 1 << amt (exactly one bit set); amt >= N -> sel = 0. The shifter's lowest set bit wins and sel = 0 yields 0, so the result is 0 for amt >= N.
- Sticky at accept: amt = 0 -> 0; 0 < amt < N -> |(in_data & ((1<<amt)-1)); amt >= N -> |in_data.
- sh_x = s1_x and sh_sel = s1_sel, driven directly from the S1 registers with no logic in between.
- advance = !out_valid || out_ready. in_ready = !s1_valid || advance. Accept = in_valid && in_ready.
- On advance: out_valid <= s1_valid. When s1_valid: out_data <= sh_o, out_zero <= (sh_o == 0), out_sticky <= s1_sticky, out_tag <= s1_tag.
- On accept: S1 loads the new request, s1_valid <= 1, and the tag counter increments (wraps 255 -> 0). If S1 advances or is empty and there is no accept: s1_valid <= 0.
- If !advance (out_valid && !out_ready): S2 and S1 hold, in_ready = !s1_valid.
- out_* are stable while out_valid && !out_ready. Upstream must hold in_data/in_amt stable while in_valid && !in_ready.

## Timing
- Reset (rst = 1 at an edge): s1_valid = 0, s1_x = 0, s1_sel = 0, s1_sticky = 0, tag counter = 0, out_valid = 0, out_data = 0, out_sticky = 0, out_zero = 0, out_tag = 0. Next cycle in_ready = 1.
- Reset mid-operation drops all in-flight requests with no output for them. The tag restarts at 0.
- Latency: a request accepted at edge k has out_valid = 1 after edge k+1, for 2 edges total counting accept.
- Throughput: 1 per cycle with out_ready held at 1. A bubble in in_valid propagates as out_valid = 0.
- Simultaneous S2 drain (out_ready) and new accept in the same cycle: both occur, and there is no bubble.
- Backpressure: with out_ready = 0, at most 2 requests are buffered (S1 + S2). in_ready falls combinationally once both are full and rises in the same cycle out_ready rises.
- in_ready depends combinationally on out_ready. No other comb in->out paths besides sh_o -> capture.

## Test plan
- Reset then single request: data 0xB5A3, amt 4 -> 2 cycles later out_data 0x0B5A, sticky 1, zero 0, tag 0.
- Boundaries: amt 0 on 0x8001 -> 0x8001, sticky 0; amt 15 on 0x8001 -> 0x0001, sticky 1; amt 16 on 0x8001 -> 0x0000, sticky 1, zero 1; amt 16 on 0x0000 -> zero 1, sticky 0.
- Streaming with out_ready = 1: 300 back-to-back random requests. Each result must match the model, tag must wrap 255 -> 0, and out_valid must stay continuous.
- Backpressure: out_ready = 0 for 5 cycles while 4 requests are offered. Exactly 2 are accepted, and in_ready = 0 afterwards. out_* hold stable. On release, results come out in order with no loss.
- Reset mid-stream: assert rst with both stages full. Next cycle out_valid = 0 and in_ready = 1. The next accepted request carries tag 0.
- Random valid/ready toggling for 10k cycles against the reference model: scoreboard data, sticky, zero and tag, and check stability while out_valid && !out_ready.

Source files
------------

// File: rtl/shift_issue.sv
// Issue/capture stage around an external combinational right shifter.
// Two-entry valid/ready pipeline: S1 holds decoded requests, S2 holds results.
module shift_issue #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  input  logic [W:0]   in_amt,
  output logic [N-1:0] sh_x,
  output logic [N-1:0] sh_sel,
  input  logic [N-1:0] sh_o,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_sticky,
  output logic         out_zero,
  output logic [7:0]   out_tag
);

  logic         s1_valid;
  logic [N-1:0] s1_x;
  logic [N-1:0] s1_sel;
  logic         s1_sticky;
  logic [7:0]   s1_tag;
  logic [7:0]   tag_cnt;

  logic         advance;
  logic         accept;
  logic [N-1:0] sel_d;
  logic         sticky_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = !s1_valid || advance;
  assign accept   = in_valid && in_ready;

  assign sh_x   = s1_x;
  assign sh_sel = s1_sel;

  // One-hot select for amt < N; amounts >= N match no line and leave sel = 0.
  // Sticky ORs every bit below the amount, which covers the >= N case too.
  always_comb begin
    sel_d    = '0;
    sticky_d = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(in_amt) == i) sel_d[i] = 1'b1;
      if (i < 32'(in_amt))  sticky_d = sticky_d | in_data[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_x       <= '0;
      s1_sel     <= '0;
      s1_sticky  <= 1'b0;
      s1_tag     <= '0;
      tag_cnt    <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
      out_tag    <= '0;
    end else begin
      if (advance) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_data   <= sh_o;
          out_zero   <= (sh_o == '0);
          out_sticky <= s1_sticky;
          out_tag    <= s1_tag;
        end
      end
      if (accept) begin
        s1_valid  <= 1'b1;
        s1_x      <= in_data;
        s1_sel    <= sel_d;
        s1_sticky <= sticky_d;
        s1_tag    <= tag_cnt;
        tag_cnt   <= tag_cnt + 8'd1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Bench for shift_issue: models the external shifter, keeps a queue-based
// reference of expected results, and runs directed plus random traffic.
module tb_shift_issue;

  localparam int N = 16;
  localparam int W = $clog2(N);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [W:0]   in_amt;
  logic [N-1:0] sh_x;
  logic [N-1:0] sh_sel;
  logic [N-1:0] sh_o;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_sticky;
  logic         out_zero;
  logic [7:0]   out_tag;

  int n_cmp = 0;
  int n_bad = 0;

  shift_issue #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
    .sh_x(sh_x), .sh_sel(sh_sel), .sh_o(sh_o),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sticky(out_sticky), .out_zero(out_zero), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter: lowest set select line i yields x >> i; no line set yields 0.
  function automatic logic [N-1:0] shifter(input logic [N-1:0] x, input logic [N-1:0] s);
    for (int i = 0; i < N; i++)
      if (s[i]) return x >> i;
    return '0;
  endfunction

  always_comb sh_o = shifter(sh_x, sh_sel);

  typedef struct {
    logic [N-1:0] data;
    logic         sticky;
    logic         zero;
    logic [7:0]   tag;
  } res_t;

  // Sticky is set when shifting back does not restore the operand.
  function automatic res_t model(input logic [N-1:0] d, input logic [W:0] a, input logic [7:0] t);
    res_t r;
    logic [31:0] wide;
    logic [31:0] sh;
    wide     = 32'(d);
    sh       = wide >> a;
    r.data   = sh[N-1:0];
    r.sticky = ((sh << a) != wide);
    r.zero   = (sh == 32'd0);
    r.tag    = t;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference scoreboard and output-stability monitor, sampled mid-cycle.
  res_t         q[$];
  logic [7:0]   tagc = 8'd0;
  logic         hold = 1'b0;
  logic [N-1:0] h_data;
  logic         h_sticky, h_zero;
  logic [7:0]   h_tag;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      tagc = 8'd0;
      hold = 1'b0;
    end else begin
      if (hold) begin
        n_cmp++;
        if (!out_valid || out_data != h_data || out_sticky != h_sticky ||
            out_zero != h_zero || out_tag != h_tag) begin
          n_bad++;
          $display("FAIL hold: got v=%b d=%h s=%b z=%b t=%h expected v=1 d=%h s=%b z=%b t=%h",
                   out_valid, out_data, out_sticky, out_zero, out_tag,
                   h_data, h_sticky, h_zero, h_tag);
        end
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL result: got unexpected output d=%h t=%h expected none", out_data, out_tag);
        end else begin
          res_t e;
          e = q.pop_front();
          if (out_data != e.data || out_sticky != e.sticky || out_zero != e.zero || out_tag != e.tag) begin
            n_bad++;
            $display("FAIL result: got d=%h s=%b z=%b t=%h expected d=%h s=%b z=%b t=%h",
                     out_data, out_sticky, out_zero, out_tag, e.data, e.sticky, e.zero, e.tag);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_data, in_amt, tagc));
        tagc = tagc + 8'd1;
      end
      hold     = out_valid && !out_ready;
      h_data   = out_data;
      h_sticky = out_sticky;
      h_zero   = out_zero;
      h_tag    = out_tag;
    end
  end

  // Single request into an empty pipeline, with literal expectations.
  task automatic directed(input logic [N-1:0] d, input logic [W:0] a, input logic [N-1:0] ed,
                          input logic es, input logic ez, input logic [7:0] et);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_not_yet", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("lat_valid", int'(out_valid), 1);
    chk("dir_data", int'(out_data), int'(ed));
    chk("dir_sticky", int'(out_sticky), int'(es));
    chk("dir_zero", int'(out_zero), int'(ez));
    chk("dir_tag", int'(out_tag), int'(et));
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [N-1:0] bp_d [4];
    logic [W:0]   bp_a [4];
    logic         a;
    int           idx;
    int           guard;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_tag", int'(out_tag), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst = 1'b0;
    @(posedge clk); #1;

    directed(16'hB5A3, 5'd4,  16'h0B5A, 1'b1, 1'b0, 8'd0);
    directed(16'h8001, 5'd0,  16'h8001, 1'b0, 1'b0, 8'd1);
    directed(16'h8001, 5'd15, 16'h0001, 1'b1, 1'b0, 8'd2);
    directed(16'h8001, 5'd16, 16'h0000, 1'b1, 1'b1, 8'd3);
    directed(16'h0000, 5'd16, 16'h0000, 1'b0, 1'b1, 8'd4);

    // Back-to-back stream; tag wraps past 255 within it.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = N'($urandom);
      in_amt  = (W+1)'($urandom_range(0, N));
      @(posedge clk); #1;
      if (i >= 1) chk("stream_continuous", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four offered, only two fit while the output is stalled.
    bp_d = '{16'hFFFF, 16'h1234, 16'hA5A5, 16'h0F0F};
    bp_a = '{5'd1, 5'd3, 5'd8, 5'd16};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      in_data = bp_d[idx];
      in_amt  = bp_a[idx];
      @(negedge clk) a = in_ready;
      @(posedge clk); #1;
      if (a && idx < 3) idx++;
    end
    in_data = bp_d[idx];
    in_amt  = bp_a[idx];
    #1;
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready_low", int'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_rise", int'(in_ready), 1);
    guard = 0;
    while (idx < 4 && guard < 20) begin
      in_data = bp_d[idx];
      in_amt  = bp_a[idx];
      @(negedge clk) a = in_ready;
      @(posedge clk); #1;
      if (a) idx++;
      guard++;
    end
    chk("bp_all_sent", idx, 4);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset with both stages occupied.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h7777;
    in_amt    = 5'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_full", int'(in_ready), 0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    directed(16'h1234, 5'd8, 16'h0012, 1'b1, 1'b0, 8'd0);

    // Random valid/ready traffic; offers hold until accepted.
    in_valid = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk) a = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || a) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = N'($urandom);
        in_amt   = (W+1)'($urandom_range(0, N));
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    chk("drain_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
